// File: rtl/zpu_sd_pkg.sv
//------------------------------------------------------------------------------
// zpu_sd_pkg : shared field indices and transfer states for the ZPU SD bridge
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package zpu_sd_pkg;

  // zpu_out2 command bits
  localparam int OUT2_LBA_SEL  = 0;
  localparam int OUT2_BLOCK_RD = 1;
  localparam int OUT2_BLOCK_WR = 2;
  localparam int OUT2_SLOT     = 3;
  // Slot field is decoded at full 3-bit width so out-of-range slots are caught
  localparam int SLOT_FIELD_W  = 3;

  // zpu_in2 status fields
  localparam int IN2_IO_DONE   = 0;
  localparam int IN2_TOGGLE    = 1;
  localparam int IN2_FILENO    = 2;
  localparam int IN2_FILETYPE  = 5;
  localparam int IN2_READONLY  = 7;
  localparam int IN2_ERROR     = 8;
  localparam int IN2_BUSY      = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } xfer_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/zpu_mount_queue.sv
//------------------------------------------------------------------------------
// zpu_mount_queue : per-slot image info and paced, lowest-first mount reports
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module zpu_mount_queue
  import zpu_sd_pkg::*;
#(
  parameter int NUM_IMG = 4
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [NUM_IMG-1:0] img_mounted,
  input  logic [NUM_IMG-1:0] img_readonly,
  input  logic [31:0]        img_size,
  input  logic [1:0]         img_type,
  output logic               mount_toggle,
  output logic [2:0]         fileno,
  output logic [1:0]         filetype,
  output logic               readonly,
  output logic [31:0]        filesize
);

  localparam int IDX_W = idx_width(NUM_IMG);

  logic [NUM_IMG-1:0] mnt_q;
  logic [NUM_IMG-1:0] mnt_rise;
  logic [NUM_IMG-1:0] pending;
  logic [NUM_IMG-1:0] pick_oh;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   cur;
  logic [1:0]         rep_hist;
  logic               report;

  logic [31:0]        size_tab [NUM_IMG];
  logic [1:0]         type_tab [NUM_IMG];
  logic [NUM_IMG-1:0] ro_tab;

  assign mnt_rise = img_mounted & ~mnt_q;
  assign report   = (|pending) && (rep_hist == 2'b00);
  assign filesize = size_tab[cur];

  always_comb begin
    pick    = '0;
    pick_oh = '0;
    for (int i = NUM_IMG - 1; i >= 0; i--) begin
      if (pending[i]) begin
        pick    = IDX_W'(i);
        pick_oh = '0;
        pick_oh[i] = 1'b1;
      end
    end
  end

  // Image info survives core reset so firmware can re-enumerate after it
  always_ff @(posedge clk_sys) begin
    for (int i = 0; i < NUM_IMG; i++) begin
      if (mnt_rise[i]) begin
        size_tab[i] <= img_size;
        type_tab[i] <= img_type;
        ro_tab[i]   <= img_readonly[i];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mnt_q    <= '0;
      rep_hist <= '0;
      cur      <= '0;
      fileno   <= '0;
      filetype <= '0;
      readonly <= 1'b0;
      for (int i = 0; i < NUM_IMG; i++) begin
        pending[i] <= (size_tab[i] != 32'd0);
      end
    end else begin
      mnt_q    <= img_mounted;
      rep_hist <= {rep_hist[0], report};
      if (report) begin
        mount_toggle <= ~mount_toggle;
        cur          <= pick;
        fileno       <= 3'(pick);
        filetype     <= type_tab[pick];
        readonly     <= ro_tab[pick];
      end
      // A new mount in the same cycle as its report keeps the slot pending
      pending <= (pending & ~(report ? pick_oh : '0)) | mnt_rise;
    end
  end

endmodule

`default_nettype wire

// File: rtl/zpu_sd_bridge_mc.sv
//------------------------------------------------------------------------------
// zpu_sd_bridge_mc : multi-image ZPU register <-> hps_io SD block bridge
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module zpu_sd_bridge_mc
  import zpu_sd_pkg::*;
#(
  parameter int NUM_IMG     = 4,
  parameter int BUF_AW      = 9,
  parameter int TIMEOUT_CYC = 2**24
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [31:0]        zpu_out2,
  input  logic [31:0]        zpu_out3,
  input  logic               zpu_io_wr,
  input  logic               zpu_data_wr,
  input  logic               zpu_data_rd,
  output logic [15:0]        zpu_in2,
  output logic [31:0]        zpu_in3,
  input  logic [NUM_IMG-1:0] img_mounted,
  input  logic [NUM_IMG-1:0] img_readonly,
  input  logic [63:0]        img_size,
  input  logic [7:0]         ioctl_index,
  output logic [31:0]        sd_lba,
  output logic [NUM_IMG-1:0] sd_rd,
  output logic [NUM_IMG-1:0] sd_wr,
  input  logic [NUM_IMG-1:0] sd_ack,
  output logic [BUF_AW-1:0]  buf_addr,
  output logic [7:0]         buf_dout,
  output logic               buf_wr,
  input  logic [7:0]         buf_q
);

  localparam int IDX_W = idx_width(NUM_IMG);
  localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  logic dwr_q1, dwr_q2, drd_q, blk_rd_q, blk_wr_q;
  logic wr_edge, rd_fall, blk_rd_rise, blk_wr_rise, lba_sel;
  logic [SLOT_FIELD_W-1:0] req_slot;

  xfer_state_t       state, state_d;
  logic [IDX_W-1:0]  slot, slot_d;
  logic              is_wr, is_wr_d;
  logic [TO_W-1:0]   cnt, cnt_d;
  logic              io_done, io_done_d;
  logic              busy, busy_d;
  logic              error, error_d;
  logic              ack_sel, ack_q;
  logic [NUM_IMG-1:0] slot_oh;

  logic              mount_toggle, readonly;
  logic [2:0]        fileno;
  logic [1:0]        filetype;
  logic [31:0]       filesize;

  logic              unused_inputs;
  assign unused_inputs = &{1'b0, zpu_out2[31:OUT2_SLOT+SLOT_FIELD_W], img_size[63:32], ioctl_index[5:0]};

  assign lba_sel     = zpu_out2[OUT2_LBA_SEL];
  assign req_slot    = zpu_out2[OUT2_SLOT +: SLOT_FIELD_W];
  assign wr_edge     = dwr_q1 & ~dwr_q2;
  assign rd_fall     = drd_q & ~zpu_data_rd;
  assign blk_rd_rise = zpu_out2[OUT2_BLOCK_RD] & ~blk_rd_q;
  assign blk_wr_rise = zpu_out2[OUT2_BLOCK_WR] & ~blk_wr_q;
  assign ack_sel     = sd_ack[slot];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dwr_q1   <= 1'b0;
      dwr_q2   <= 1'b0;
      drd_q    <= 1'b0;
      blk_rd_q <= 1'b0;
      blk_wr_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      dwr_q1   <= zpu_data_wr;
      dwr_q2   <= dwr_q1;
      drd_q    <= zpu_data_rd;
      blk_rd_q <= zpu_out2[OUT2_BLOCK_RD];
      blk_wr_q <= zpu_out2[OUT2_BLOCK_WR];
      ack_q    <= ack_sel;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sd_lba   <= '0;
      buf_wr   <= 1'b0;
      buf_dout <= '0;
      buf_addr <= '0;
    end else begin
      buf_wr <= wr_edge & ~lba_sel;
      if (wr_edge && lba_sel)  sd_lba   <= zpu_out3;
      if (wr_edge && !lba_sel) buf_dout <= zpu_out3[7:0];
      if (zpu_io_wr)                buf_addr <= '0;
      else if (buf_wr || rd_fall)   buf_addr <= buf_addr + BUF_AW'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state   <= IDLE;
      slot    <= '0;
      is_wr   <= 1'b0;
      cnt     <= '0;
      io_done <= 1'b1;
      busy    <= 1'b0;
      error   <= 1'b0;
    end else begin
      state   <= state_d;
      slot    <= slot_d;
      is_wr   <= is_wr_d;
      cnt     <= cnt_d;
      io_done <= io_done_d;
      busy    <= busy_d;
      error   <= error_d;
    end
  end

  always_comb begin
    state_d   = state;
    slot_d    = slot;
    is_wr_d   = is_wr;
    cnt_d     = cnt;
    io_done_d = io_done;
    busy_d    = busy;
    error_d   = error;
    unique case (state)
      IDLE: begin
        if (blk_rd_rise || blk_wr_rise) begin
          if (int'(req_slot) >= NUM_IMG) begin
            error_d   = 1'b1;
            io_done_d = 1'b1;
          end else if (!blk_rd_rise && img_readonly[req_slot[IDX_W-1:0]]) begin
            error_d   = 1'b1;
            io_done_d = 1'b1;
          end else begin
            slot_d    = req_slot[IDX_W-1:0];
            is_wr_d   = ~blk_rd_rise;
            cnt_d     = '0;
            io_done_d = 1'b0;
            busy_d    = 1'b1;
            error_d   = 1'b0;
            state_d   = REQ;
          end
        end
      end
      REQ: begin
        if (ack_sel) begin
          state_d = XFER;
        end else if (TIMEOUT_CYC != 0 && cnt == TO_LAST) begin
          error_d = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt + TO_W'(1);
        end
      end
      XFER: begin
        if (ack_q && !ack_sel) state_d = DONE;
      end
      DONE: begin
        io_done_d = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar i = 0; i < NUM_IMG; i++) begin : g_slot_oh
    assign slot_oh[i] = (slot == IDX_W'(i));
  end

  // Requests are gated by reset so they drop in the reset cycle itself
  assign sd_rd = (state == REQ && !is_wr && !reset) ? slot_oh : '0;
  assign sd_wr = (state == REQ &&  is_wr && !reset) ? slot_oh : '0;

  zpu_mount_queue #(
    .NUM_IMG(NUM_IMG)
  ) u_mount_queue (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .img_mounted  (img_mounted),
    .img_readonly (img_readonly),
    .img_size     (img_size[31:0]),
    .img_type     (ioctl_index[7:6]),
    .mount_toggle (mount_toggle),
    .fileno       (fileno),
    .filetype     (filetype),
    .readonly     (readonly),
    .filesize     (filesize)
  );

  assign zpu_in2 = {6'd0, busy, error, readonly, filetype, fileno, mount_toggle, io_done};
  assign zpu_in3 = lba_sel ? filesize : {24'd0, buf_q};

endmodule

`default_nettype wire

// File: tb/tb_zpu_sd_bridge_mc.sv
//------------------------------------------------------------------------------
// tb_zpu_sd_bridge_mc : directed, table-driven bench for zpu_sd_bridge_mc
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_zpu_sd_bridge_mc;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [31:0] zpu_out2, zpu_out3;
  logic        zpu_io_wr, zpu_data_wr, zpu_data_rd;
  logic [15:0] zpu_in2;
  logic [31:0] zpu_in3;
  logic [3:0]  img_mounted, img_readonly;
  logic [63:0] img_size;
  logic [7:0]  ioctl_index;
  logic [31:0] sd_lba;
  logic [3:0]  sd_rd, sd_wr, sd_ack;
  logic [8:0]  buf_addr;
  logic [7:0]  buf_dout;
  logic        buf_wr;
  logic [7:0]  buf_q;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  zpu_sd_bridge_mc #(
    .NUM_IMG(4), .BUF_AW(9), .TIMEOUT_CYC(16)
  ) dut (
    .clk_sys(clk_sys), .reset(reset),
    .zpu_out2(zpu_out2), .zpu_out3(zpu_out3),
    .zpu_io_wr(zpu_io_wr), .zpu_data_wr(zpu_data_wr), .zpu_data_rd(zpu_data_rd),
    .zpu_in2(zpu_in2), .zpu_in3(zpu_in3),
    .img_mounted(img_mounted), .img_readonly(img_readonly),
    .img_size(img_size), .ioctl_index(ioctl_index),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .buf_addr(buf_addr), .buf_dout(buf_dout), .buf_wr(buf_wr), .buf_q(buf_q)
  );

  typedef struct {
    logic        lba;
    logic [31:0] data;
    logic        exp_wr;
    logic [7:0]  exp_dout;
    logic [31:0] exp_lba;
    logic [8:0]  exp_addr;
  } wvec_t;

  wvec_t vecs[5];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk2(input logic lba, input logic rd, input logic wr,
                                      input logic [2:0] slot);
    return {26'd0, slot, wr, rd, lba};
  endfunction

  // Strobe one data write and stop where buf_wr is visible (before the address step)
  task automatic zwrite(input logic lba, input logic [31:0] d);
    zpu_out2[0] = lba;
    zpu_out3    = d;
    zpu_data_wr = 1'b1;
    tick();
    zpu_data_wr = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic       t0;
    int         n;

    vecs[0] = '{1'b1, 32'h0000_1234, 1'b0, 8'h00, 32'h0000_1234, 9'd0};
    vecs[1] = '{1'b0, 32'h0000_00A5, 1'b1, 8'hA5, 32'h0000_1234, 9'd1};
    vecs[2] = '{1'b0, 32'h0000_013C, 1'b1, 8'h3C, 32'h0000_1234, 9'd2};
    vecs[3] = '{1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00, 32'hDEAD_BEEF, 9'd2};
    vecs[4] = '{1'b0, 32'h0000_00FF, 1'b1, 8'hFF, 32'hDEAD_BEEF, 9'd3};

    reset = 1'b1;
    zpu_out2 = '0; zpu_out3 = '0;
    zpu_io_wr = 1'b0; zpu_data_wr = 1'b0; zpu_data_rd = 1'b0;
    img_mounted = '0; img_readonly = '0; img_size = '0; ioctl_index = '0;
    sd_ack = '0; buf_q = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state (mount_toggle is not defined by reset)
    chk("reset_in2", {16'd0, zpu_in2 & 16'hFFFD}, 32'h0000_0001);
    chk("reset_sd_rd", {28'd0, sd_rd}, 32'd0);
    chk("reset_sd_wr", {28'd0, sd_wr}, 32'd0);
    chk("reset_buf_wr", {31'd0, buf_wr}, 32'd0);
    chk("reset_buf_addr", {23'd0, buf_addr}, 32'd0);
    chk("reset_sd_lba", sd_lba, 32'd0);

    // Table-driven data writes
    for (int i = 0; i < 5; i++) begin
      zwrite(vecs[i].lba, vecs[i].data);
      chk($sformatf("vec%0d_buf_wr", i), {31'd0, buf_wr}, {31'd0, vecs[i].exp_wr});
      if (vecs[i].exp_wr)
        chk($sformatf("vec%0d_dout", i), {24'd0, buf_dout}, {24'd0, vecs[i].exp_dout});
      tick();
      chk($sformatf("vec%0d_buf_wr_gone", i), {31'd0, buf_wr}, 32'd0);
      chk($sformatf("vec%0d_sd_lba", i), sd_lba, vecs[i].exp_lba);
      chk($sformatf("vec%0d_addr", i), {23'd0, buf_addr}, {23'd0, vecs[i].exp_addr});
    end

    zpu_out2 = '0;
    buf_q = 8'h5A;
    #1;
    chk("in3_buf_q", zpu_in3, 32'h0000_005A);

    // Read strobe falling edge advances the address
    zpu_data_rd = 1'b1; tick();
    zpu_data_rd = 1'b0; tick();
    chk("rd_fall_addr", {23'd0, buf_addr}, 32'd4);

    // io_wr clears and wins over a same-cycle increment
    zpu_io_wr = 1'b1;
    zwrite(1'b0, 32'h11);
    tick();
    chk("io_wr_priority", {23'd0, buf_addr}, 32'd0);
    zpu_io_wr = 1'b0;
    tick();

    // 514 buffer writes: addresses 0..511 then wrap to 0, 1
    for (int i = 0; i < 514; i++) begin
      zwrite(1'b0, 32'(i % 256));
      chk($sformatf("bulk%0d_wr", i), {31'd0, buf_wr}, 32'd1);
      chk($sformatf("bulk%0d_addr", i), {23'd0, buf_addr}, 32'(i % 512));
      chk($sformatf("bulk%0d_dout", i), {24'd0, buf_dout}, 32'(i % 256));
      tick();
    end
    chk("bulk_final_addr", {23'd0, buf_addr}, 32'd2);

    // Block read on slot 2
    zwrite(1'b1, 32'h1234);
    tick();
    chk("blk_lba", sd_lba, 32'h0000_1234);
    zpu_out2 = mk2(1'b0, 1'b1, 1'b0, 3'd2);
    tick();
    chk("rd_req", {28'd0, sd_rd}, 32'h4);
    chk("rd_no_wr", {28'd0, sd_wr}, 32'h0);
    chk("rd_busy", {31'd0, zpu_in2[9]}, 32'd1);
    chk("rd_io_done_low", {31'd0, zpu_in2[0]}, 32'd0);
    repeat (3) tick();
    chk("rd_req_held", {28'd0, sd_rd}, 32'h4);
    sd_ack = 4'b0100;
    tick();
    chk("rd_req_dropped", {28'd0, sd_rd}, 32'h0);
    repeat (4) tick();
    sd_ack = 4'b0000;
    tick();
    chk("rd_not_done_yet", {31'd0, zpu_in2[0]}, 32'd0);
    tick();
    chk("rd_done", {31'd0, zpu_in2[0]}, 32'd1);
    chk("rd_busy_clear", {31'd0, zpu_in2[9]}, 32'd0);
    chk("rd_no_error", {31'd0, zpu_in2[8]}, 32'd0);
    zpu_out2 = '0;
    tick();

    // Write to a read-only slot is rejected
    img_readonly = 4'b0010;
    zpu_out2 = mk2(1'b0, 1'b0, 1'b1, 3'd1);
    tick();
    chk("ro_error", {31'd0, zpu_in2[8]}, 32'd1);
    chk("ro_io_done", {31'd0, zpu_in2[0]}, 32'd1);
    chk("ro_not_busy", {31'd0, zpu_in2[9]}, 32'd0);
    tick();
    chk("ro_no_sd_wr", {28'd0, sd_wr}, 32'd0);
    zpu_out2 = '0;
    tick();

    // Slot beyond NUM_IMG is rejected
    zpu_out2 = mk2(1'b0, 1'b1, 1'b0, 3'd5);
    tick();
    chk("slot5_error", {31'd0, zpu_in2[8]}, 32'd1);
    chk("slot5_io_done", {31'd0, zpu_in2[0]}, 32'd1);
    tick();
    chk("slot5_no_rd", {28'd0, sd_rd}, 32'd0);
    zpu_out2 = '0;
    tick();

    // Timeout with no acknowledge
    zpu_out2 = mk2(1'b0, 1'b1, 1'b0, 3'd0);
    tick();
    chk("to_error_cleared", {31'd0, zpu_in2[8]}, 32'd0);
    n = 0;
    while (sd_rd != 4'd0 && n < 40) begin
      n++;
      tick();
    end
    chk("to_req_cycles", 32'(n), 32'd16);
    chk("to_error", {31'd0, zpu_in2[8]}, 32'd1);
    tick();
    chk("to_io_done", {31'd0, zpu_in2[0]}, 32'd1);
    zpu_out2 = '0;
    tick();

    // Simultaneous mounts on slots 1 and 3
    zpu_out2 = mk2(1'b1, 1'b0, 1'b0, 3'd0);
    img_size = 64'h0000_0001_0000_4000;
    ioctl_index = 8'h80;
    t0 = zpu_in2[1];
    img_mounted = 4'b1010;
    tick();
    img_mounted = 4'b0000;
    chk("mnt_no_report_yet", {31'd0, zpu_in2[1]}, {31'd0, t0});
    tick();
    chk("mnt1_toggle", {31'd0, zpu_in2[1]}, {31'd0, ~t0});
    chk("mnt1_fileno", {29'd0, zpu_in2[4:2]}, 32'd1);
    chk("mnt1_type", {30'd0, zpu_in2[6:5]}, 32'd2);
    chk("mnt1_ro", {31'd0, zpu_in2[7]}, 32'd1);
    chk("mnt1_size", zpu_in3, 32'h0000_4000);
    tick();
    tick();
    chk("mnt_paced", {31'd0, zpu_in2[1]}, {31'd0, ~t0});
    tick();
    chk("mnt3_toggle", {31'd0, zpu_in2[1]}, {31'd0, t0});
    chk("mnt3_fileno", {29'd0, zpu_in2[4:2]}, 32'd3);
    chk("mnt3_ro", {31'd0, zpu_in2[7]}, 32'd0);
    chk("mnt3_size", zpu_in3, 32'h0000_4000);

    // Re-mount slot 3 with a new size and type
    repeat (3) tick();
    img_size = 64'h0000_0000_0000_8000;
    ioctl_index = 8'h40;
    img_mounted = 4'b1000;
    tick();
    img_mounted = 4'b0000;
    tick();
    chk("remnt_toggle", {31'd0, zpu_in2[1]}, {31'd0, ~t0});
    chk("remnt_fileno", {29'd0, zpu_in2[4:2]}, 32'd3);
    chk("remnt_type", {30'd0, zpu_in2[6:5]}, 32'd1);
    chk("remnt_size", zpu_in3, 32'h0000_8000);
    repeat (3) tick();
    chk("remnt_single", {31'd0, zpu_in2[1]}, {31'd0, ~t0});

    // Reset while in XFER, then re-enumeration of non-empty slots
    zpu_out2 = mk2(1'b0, 1'b1, 1'b0, 3'd3);
    tick();
    chk("rx_req", {28'd0, sd_rd}, 32'h8);
    sd_ack = 4'b1000;
    tick();
    zpu_out2 = mk2(1'b1, 1'b0, 1'b0, 3'd0);
    tick();
    chk("rx_in_xfer_busy", {31'd0, zpu_in2[9]}, 32'd1);
    reset = 1'b1;
    tick();
    chk("rx_io_done", {31'd0, zpu_in2[0]}, 32'd1);
    chk("rx_not_busy", {31'd0, zpu_in2[9]}, 32'd0);
    chk("rx_sd_rd", {28'd0, sd_rd}, 32'd0);
    chk("rx_sd_wr", {28'd0, sd_wr}, 32'd0);
    sd_ack = 4'b0000;
    t0 = zpu_in2[1];
    reset = 1'b0;
    tick();
    chk("rr1_toggle", {31'd0, zpu_in2[1]}, {31'd0, ~t0});
    chk("rr1_fileno", {29'd0, zpu_in2[4:2]}, 32'd1);
    chk("rr1_size", zpu_in3, 32'h0000_4000);
    repeat (3) tick();
    chk("rr3_toggle", {31'd0, zpu_in2[1]}, {31'd0, t0});
    chk("rr3_fileno", {29'd0, zpu_in2[4:2]}, 32'd3);
    chk("rr3_size", zpu_in3, 32'h0000_8000);
    chk("rr_no_error", {31'd0, zpu_in2[8]}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
